// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the RV32IM core. Captures decoded
//               fields from ID, detects load-use hazards (stall + bubble),
//               resolves EX/MEM and MEM/WB forwarding and drives the ALU
//               operands, opcode and the control fields carried into EX/MEM.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  // Decoded instruction from ID
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [4:0]      id_alu_op,
  input  logic            id_src_pc,
  input  logic            id_src_imm,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  // Taken branch/jump resolved in EX
  input  logic            flush,
  // Forwarding sources
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  // Hazard output
  output logic            stall_id,
  // ALU inputs
  output logic [XLEN-1:0] DATA1,
  output logic [XLEN-1:0] DATA2,
  output logic [4:0]      ALU_OPCODE,
  // Control carried into EX/MEM
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write
);

  // --------------------------------------------------------------------------
  // Pipeline register state
  // --------------------------------------------------------------------------
  logic            valid_q,     valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [4:0]      rs1_addr_q,  rs1_addr_d;
  logic [4:0]      rs2_addr_q,  rs2_addr_d;
  logic [4:0]      rd_q,        rd_d;
  logic [4:0]      alu_op_q,    alu_op_d;
  logic            src_pc_q,    src_pc_d;
  logic            src_imm_q,   src_imm_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic            uses_rs1_q,  uses_rs1_d;
  logic            uses_rs2_q,  uses_rs2_d;

  logic            rs1_hit;
  logic            rs2_hit;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // The source-use flags travel with the instruction for downstream
  // visibility; forwarding keys purely on register indices.
  logic unused_uses;
  assign unused_uses = uses_rs1_q ^ uses_rs2_q;

  // --------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by the ID
  // instruction. A flush kills the ID instruction, so it cannot stall.
  // --------------------------------------------------------------------------
  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == rd_q);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == rd_q);
  assign load_use = valid_q && mem_read_q && (rd_q != 5'd0) && id_valid &&
                    (rs1_hit || rs2_hit);
  assign stall_id = load_use && !flush;

  // Next-state select: capture ID fields, or an all-zero bubble on flush/stall
  always_comb begin
    valid_d     = id_valid;
    pc_d        = id_pc;
    rs1_data_d  = id_rs1_data;
    rs2_data_d  = id_rs2_data;
    imm_d       = id_imm;
    rs1_addr_d  = id_rs1_addr;
    rs2_addr_d  = id_rs2_addr;
    rd_d        = id_rd_addr;
    alu_op_d    = id_alu_op;
    src_pc_d    = id_src_pc;
    src_imm_d   = id_src_imm;
    mem_read_d  = id_mem_read;
    mem_write_d = id_mem_write;
    reg_write_d = id_reg_write;
    uses_rs1_d  = id_uses_rs1;
    uses_rs2_d  = id_uses_rs2;
    if (flush || stall_id) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_addr_d  = 5'd0;
      rs2_addr_d  = 5'd0;
      rd_d        = 5'd0;
      alu_op_d    = 5'd0;
      src_pc_d    = 1'b0;
      src_imm_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
      uses_rs1_d  = 1'b0;
      uses_rs2_d  = 1'b0;
    end
  end

  // Pipeline register update with synchronous reset to the bubble state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rd_q        <= 5'd0;
      alu_op_q    <= 5'd0;
      src_pc_q    <= 1'b0;
      src_imm_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      uses_rs1_q  <= 1'b0;
      uses_rs2_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      src_pc_q    <= src_pc_d;
      src_imm_q   <= src_imm_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      uses_rs1_q  <= uses_rs1_d;
      uses_rs2_q  <= uses_rs2_d;
    end
  end

  // Forward rs1: EX/MEM first, then MEM/WB; x0 is never forwarded
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q)) begin
      fwd_rs1 = memwb_result;
    end
  end

  // Forward rs2: EX/MEM first, then MEM/WB; x0 is never forwarded
  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q)) begin
      fwd_rs2 = memwb_result;
    end
  end

  // --------------------------------------------------------------------------
  // Operand muxes and registered outputs. Store data always takes the
  // forwarded rs2 since DATA2 carries the address offset for stores.
  // --------------------------------------------------------------------------
  assign DATA1         = src_pc_q  ? pc_q  : fwd_rs1;
  assign DATA2         = src_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ALU_OPCODE    = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_reg_write  = reg_write_q;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RV32IM core, sitting directly upstream of the ALU. It captures decoded instruction fields from ID each cycle and detects load-use hazards, stalling ID and inserting a bubble. It resolves operand forwarding from EX/MEM and MEM/WB, then drives the ALU's `DATA1`, `DATA2` and `ALU_OPCODE` inputs plus the control fields carried into EX/MEM.

## Interface
- `XLEN`, 32, datapath width.
- `CLK` in 1 — single clock, rising edge.
- `RESET` in 1 — synchronous, active-high.
- `id_valid` in 1 — ID holds a real instruction.
- `id_pc` in 32 — instruction PC.
- `id_rs1_data` in 32 — register-file read, port 1.
- `id_rs2_data` in 32 — register-file read, port 2.
- `id_imm` in 32 — sign-extended immediate.
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr` in 5 each — register indices.
- `id_uses_rs1`, `id_uses_rs2` in 1 each — the instruction reads that source.
- `id_alu_op` in 5 — ALU opcode (ADD 00000 … SLT 10000, pass-data2 10001).
- `id_src_pc` in 1 — `DATA1` = PC instead of rs1.
- `id_src_imm` in 1 — `DATA2` = immediate instead of rs2.
- `id_mem_read`, `id_mem_write`, `id_reg_write` in 1 each — control.
- `flush` in 1 — taken branch/jump resolved in EX; kill the ID instruction.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32 — EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32 — MEM/WB forwarding source.
- `stall_id` out 1 — combinational; hold PC and IF/ID this cycle.
- `DATA1`, `DATA2` out 32 — ALU operands.
- `ALU_OPCODE` out 5 — ALU operation.
- `ex_valid` out 1; `ex_pc` out 32; `ex_rd` out 5.
- `ex_store_data` out 32 — forwarded rs2, for stores.
- `ex_mem_read`, `ex_mem_write`, `ex_reg_write` out 1 each.

## Operation
- **Registered state (captured each edge):**
  - valid, pc, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_op, src_pc, src_imm.
  - mem_read, mem_write, reg_write, uses_rs1, uses_rs2.
- **Load-use hazard:** `stall_id` = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & !flush & ((id_uses_rs1 & id_rs1_addr==ex_rd) | (id_uses_rs2 & id_rs2_addr==ex_rd)).
- **Edge priority:**
  - RESET: clear all registers.
  - Else flush: load a bubble.
  - Else stall_id: load a bubble (ID holds, re-presented next cycle).
  - Else capture the ID fields.
- **Bubble:**
  - valid=0 and all control bits 0.
  - alu_op=00000, data/imm/pc/addr=0.
  - It can never write or touch memory.
- **Forwarding (combinational on registered fields), per source rsN:**
  - If exmem_reg_write & exmem_rd≠0 & exmem_rd==rsN_addr → exmem_result.
  - Else if memwb_reg_write & memwb_rd≠0 & memwb_rd==rsN_addr → memwb_result.
  - Else the registered data.
  - EX/MEM has priority over MEM/WB.
  - x0 is never forwarded.
- **Operand muxes:**
  - `DATA1` = src_pc ? pc : fwd_rs1.
  - `DATA2` = src_imm ? imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2, always, independent of src_imm.
- `ALU_OPCODE` = registered alu_op; the other ex_* outputs are the registered values.

## Timing
- **Reset (after the first RESET edge):** every output 0, including `DATA1`/`DATA2`; `stall_id`=0.
- **Latency:** 1 cycle, ID fields → ex_* outputs.
- **Forward muxes:** forwarding and the operand muxes are combinational within the EX cycle; the ALU adds its own delay downstream.
- **Load-use:** the dependent instruction sees exactly one bubble. The next cycle the load is in MEM/WB and is forwarded from `memwb_result`.
- **flush with hazard:** flush and a hazard condition in the same cycle → flush wins, `stall_id`=0.
- **RESET with flush/stall:** RESET mid-stream overrides both.
- **Back-to-back stalls:** impossible; after a bubble, ex_mem_read=0.
- **Bubble forwarding:** a bubble in EX/MEM or MEM/WB carries reg_write=0, so it is never forwarded.

## Test plan
- **Reset:** RESET high 2 cycles with random ID inputs → all outputs 0 and `stall_id`=0; first valid ADD is captured one cycle after RESET falls.
- **Plain ALU-immediate:** ADDI, rs1=x5 data 0x10, imm 0x7, id_alu_op 00000, src_imm=1, no hazards → next cycle `DATA1`=0x10, `DATA2`=0x7, `ALU_OPCODE`=00000, ex_valid=1.
- **Double forward:** exmem x3=0xAAAA and memwb x3=0x5555, both writing, EX uses rs1=x3 → `DATA1`=0xAAAA. Repeat with exmem_rd=0 → `DATA1`=0x5555; with rs1=x0 → registered data.
- **Load-use:** LW x4 in EX, ID ADD reads x4 → `stall_id`=1 for one cycle and EX gets a bubble. The ADD then captures, and with memwb x4=0x1234, `DATA1`=0x1234.
- **Flush vs stall:** load-use condition and flush asserted together → `stall_id`=0 and next EX is a bubble with ex_reg_write=0.
- **Store forwarding:** SW with rs2=x7 and exmem x7=0xDEAD, src_imm=1, imm=8 → `DATA2`=8 and `ex_store_data`=0xDEAD.
